// File: rtl/gemv_seq_if.sv
// rtl/gemv_seq_if.sv - memory and GEMV core signal bundle for the layer sequencer
interface gemv_seq_if #(
  parameter int AW = 32
);
  logic          mem_rd_req;
  logic [AW-1:0] mem_rd_addr;
  logic          mem_rd_valid;
  logic [31:0]   mem_rd_data;
  logic          mem_wr_req;
  logic [AW-1:0] mem_wr_addr;
  logic [31:0]   mem_wr_data;
  logic          mem_wr_ack;
  logic          core_x_wr_en;
  logic [7:0]    core_x_wr_data;
  logic          core_w_wr_en;
  logic [7:0]    core_w_wr_data;
  logic          core_b_wr_en;
  logic [31:0]   core_b_wr_data;
  logic          core_start;
  logic          core_len_64;
  logic          core_out_64;
  logic          core_bias_en;
  logic          core_busy;
  logic          core_done;
  logic          core_clear_done;
  logic          core_y_rd_en;
  logic [31:0]   core_y_rd_data;

  modport master (
    output mem_rd_req, mem_rd_addr, input mem_rd_valid, mem_rd_data,
    output mem_wr_req, mem_wr_addr, mem_wr_data, input mem_wr_ack,
    output core_x_wr_en, core_x_wr_data, core_w_wr_en, core_w_wr_data,
    output core_b_wr_en, core_b_wr_data, core_start,
    output core_len_64, core_out_64, core_bias_en,
    input core_busy, core_done,
    output core_clear_done, core_y_rd_en, input core_y_rd_data
  );

  modport slave (
    input mem_rd_req, mem_rd_addr, output mem_rd_valid, mem_rd_data,
    input mem_wr_req, mem_wr_addr, mem_wr_data, output mem_wr_ack,
    input core_x_wr_en, core_x_wr_data, core_w_wr_en, core_w_wr_data,
    input core_b_wr_en, core_b_wr_data, core_start,
    input core_len_64, core_out_64, core_bias_en,
    output core_busy, core_done,
    input core_clear_done, core_y_rd_en, output core_y_rd_data
  );
endinterface

// File: rtl/gemv_seq.sv
// rtl/gemv_seq.sv - autonomous fetch/compute/writeback sequencer for the int8 GEMV core
module gemv_seq #(
  parameter int AW    = 32,
  parameter int CYC_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [AW-1:0]    cfg_x_base,
  input  logic [AW-1:0]    cfg_w_base,
  input  logic [AW-1:0]    cfg_b_base,
  input  logic [AW-1:0]    cfg_y_base,
  input  logic             cfg_len_64,
  input  logic             cfg_out_64,
  input  logic             cfg_bias_en,
  input  logic             cfg_relu_en,
  output logic             busy,
  output logic             done,
  output logic [CYC_W-1:0] cycles,
  gemv_seq_if.master       bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_LD_X, S_LD_W, S_LD_B, S_START, S_WAIT, S_WR_Y, S_FIN
  } state_t;

  state_t        state;
  logic [AW-1:0] x_base, w_base, b_base, y_base;
  logic          len_64, out_64, bias_en, relu_en;
  logic [10:0]   word_cnt;
  logic [1:0]    byte_idx;
  logic          pushing;
  logic [31:0]   rd_word;

  logic          rd_req, wr_req;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [31:0]   wr_data;
  logic          x_en, w_en, b_en, start_p, clr_p;
  logic [7:0]    x_data, w_data;
  logic [31:0]   b_data;

  logic [10:0]   nx, nw, ny, n_cur;
  logic [AW-1:0] base_cur;
  logic [7:0]    next_byte;
  logic [31:0]   y_wr;

  always_comb begin
    nx = len_64 ? 11'd16 : 11'd8;
    ny = out_64 ? 11'd64 : 11'd32;
    case ({out_64, len_64})
      2'b00:   nw = 11'd256;
      2'b11:   nw = 11'd1024;
      default: nw = 11'd512;
    endcase
    n_cur    = nx;
    base_cur = x_base;
    if (state == S_LD_W) begin
      n_cur    = nw;
      base_cur = w_base;
    end else if (state == S_LD_B) begin
      n_cur    = ny;
      base_cur = b_base;
    end
  end

  always_comb begin
    case (byte_idx)
      2'd1:    next_byte = rd_word[15:8];
      2'd2:    next_byte = rd_word[23:16];
      2'd3:    next_byte = rd_word[31:24];
      default: next_byte = rd_word[7:0];
    endcase
  end

  assign y_wr = (relu_en && bus.core_y_rd_data[31]) ? 32'd0 : bus.core_y_rd_data;

  assign bus.mem_rd_req      = rd_req;
  assign bus.mem_rd_addr     = rd_addr;
  assign bus.mem_wr_req      = wr_req;
  assign bus.mem_wr_addr     = wr_addr;
  assign bus.mem_wr_data     = wr_data;
  assign bus.core_x_wr_en    = x_en;
  assign bus.core_x_wr_data  = x_data;
  assign bus.core_w_wr_en    = w_en;
  assign bus.core_w_wr_data  = w_data;
  assign bus.core_b_wr_en    = b_en;
  assign bus.core_b_wr_data  = b_data;
  assign bus.core_start      = start_p;
  assign bus.core_clear_done = clr_p;
  assign bus.core_len_64     = len_64;
  assign bus.core_out_64     = out_64;
  assign bus.core_bias_en    = bias_en;
  // The Y read pointer must advance in the very cycle the write is acknowledged.
  assign bus.core_y_rd_en    = (state == S_WR_Y) && wr_req && bus.mem_wr_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      cycles   <= '0;
      x_base   <= '0;
      w_base   <= '0;
      b_base   <= '0;
      y_base   <= '0;
      len_64   <= 1'b0;
      out_64   <= 1'b0;
      bias_en  <= 1'b0;
      relu_en  <= 1'b0;
      word_cnt <= '0;
      byte_idx <= '0;
      pushing  <= 1'b0;
      rd_word  <= '0;
      rd_req   <= 1'b0;
      rd_addr  <= '0;
      wr_req   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      x_en     <= 1'b0;
      x_data   <= '0;
      w_en     <= 1'b0;
      w_data   <= '0;
      b_en     <= 1'b0;
      b_data   <= '0;
      start_p  <= 1'b0;
      clr_p    <= 1'b0;
    end else begin
      x_en    <= 1'b0;
      w_en    <= 1'b0;
      b_en    <= 1'b0;
      start_p <= 1'b0;
      clr_p   <= 1'b0;
      if (busy) cycles <= cycles + 1'b1;

      case (state)
        S_IDLE: begin
          if (go) begin
            x_base  <= cfg_x_base;
            w_base  <= cfg_w_base;
            b_base  <= cfg_b_base;
            y_base  <= cfg_y_base;
            len_64  <= cfg_len_64;
            out_64  <= cfg_out_64;
            bias_en <= cfg_bias_en;
            relu_en <= cfg_relu_en;
            busy    <= 1'b1;
            done    <= 1'b0;
            cycles  <= '0;
            clr_p   <= 1'b1;
            state   <= S_CLR;
          end
        end

        S_CLR: begin
          word_cnt <= '0;
          pushing  <= 1'b0;
          rd_req   <= 1'b1;
          rd_addr  <= x_base;
          state    <= S_LD_X;
        end

        S_LD_X, S_LD_W, S_LD_B: begin
          if (rd_req) begin
            if (bus.mem_rd_valid) begin
              rd_req   <= 1'b0;
              rd_word  <= bus.mem_rd_data;
              word_cnt <= word_cnt + 11'd1;
              pushing  <= 1'b1;
              // Bias words are a single push, so they skip straight to the drain step.
              byte_idx <= (state == S_LD_B) ? 2'd0 : 2'd1;
              if (state == S_LD_X) begin
                x_en   <= 1'b1;
                x_data <= bus.mem_rd_data[7:0];
              end else if (state == S_LD_W) begin
                w_en   <= 1'b1;
                w_data <= bus.mem_rd_data[7:0];
              end else begin
                b_en   <= 1'b1;
                b_data <= bus.mem_rd_data;
              end
            end
          end else if (pushing) begin
            if (byte_idx != 2'd0) begin
              byte_idx <= byte_idx + 2'd1;
              if (state == S_LD_X) begin
                x_en   <= 1'b1;
                x_data <= next_byte;
              end else begin
                w_en   <= 1'b1;
                w_data <= next_byte;
              end
            end else begin
              pushing <= 1'b0;
              if (word_cnt != n_cur) begin
                rd_req  <= 1'b1;
                rd_addr <= base_cur + AW'(word_cnt);
              end else begin
                word_cnt <= '0;
                if (state == S_LD_X) begin
                  rd_req  <= 1'b1;
                  rd_addr <= w_base;
                  state   <= S_LD_W;
                end else if (state == S_LD_W && bias_en) begin
                  rd_req  <= 1'b1;
                  rd_addr <= b_base;
                  state   <= S_LD_B;
                end else begin
                  start_p <= 1'b1;
                  state   <= S_START;
                end
              end
            end
          end
        end

        S_START: state <= S_WAIT;

        S_WAIT: begin
          if (bus.core_done && !bus.core_busy) begin
            word_cnt <= '0;
            state    <= S_WR_Y;
          end
        end

        S_WR_Y: begin
          if (wr_req) begin
            if (bus.mem_wr_ack) begin
              wr_req   <= 1'b0;
              word_cnt <= word_cnt + 11'd1;
              if (word_cnt + 11'd1 == ny) begin
                clr_p <= 1'b1;
                state <= S_FIN;
              end
            end
          end else begin
            // Y data is sampled one cycle after the pointer moved, so it is already the next word.
            wr_req  <= 1'b1;
            wr_addr <= y_base + AW'(word_cnt);
            wr_data <= y_wr;
          end
        end

        S_FIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gemv_seq.sv
// tb/tb_gemv_seq.sv - scoreboard bench for gemv_seq with memory and GEMV core models
module tb_gemv_seq;
  localparam int AW = 32;
  localparam logic [31:0] X_BASE = 32'h0100;
  localparam logic [31:0] B_BASE = 32'h0200;
  localparam logic [31:0] Y_BASE = 32'h0400;
  localparam logic [31:0] Y_ALT  = 32'h0600;
  localparam logic [31:0] W_BASE = 32'h1000;

  logic clk = 1'b0;
  logic reset, go;
  logic [AW-1:0] cfg_x_base, cfg_w_base, cfg_b_base, cfg_y_base;
  logic cfg_len_64, cfg_out_64, cfg_bias_en, cfg_relu_en;
  logic busy, done;
  logic [31:0] cycles;

  always #5 clk = ~clk;

  gemv_seq_if #(.AW(AW)) bus ();

  gemv_seq #(.AW(AW), .CYC_W(32)) dut (
    .clk(clk), .reset(reset), .go(go),
    .cfg_x_base(cfg_x_base), .cfg_w_base(cfg_w_base),
    .cfg_b_base(cfg_b_base), .cfg_y_base(cfg_y_base),
    .cfg_len_64(cfg_len_64), .cfg_out_64(cfg_out_64),
    .cfg_bias_en(cfg_bias_en), .cfg_relu_en(cfg_relu_en),
    .busy(busy), .done(done), .cycles(cycles), .bus(bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int checks = 0;
  int failures = 0;
  logic [31:0] mem [0:8191];
  wr_t sb [$];
  logic [31:0] rd_log [$];
  int n_x = 0, n_w = 0, n_b = 0, n_start = 0, n_clr = 0, n_wr = 0, n_yrd = 0, n_ov = 0;
  int max_stall = 0;

  logic signed [7:0] xbuf [0:63];
  logic signed [7:0] wbuf [0:4095];
  logic [31:0] bbuf [0:63];
  logic [31:0] ybuf [0:63];
  int xi = 0, wi = 0, bi = 0, yi = 0, core_cnt = 0;
  bit y_adv = 0;
  bit rd_pend = 0, wr_pend = 0;
  int rd_stall = 0, wr_stall = 0;
  logic [31:0] rd_hold, wr_hold_a, wr_hold_d;

  int exp_nx, exp_nw, exp_nb, exp_ny;
  int r0, x0, w0, b0, s0, cl0, wr0, yr0, ov0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sbyte(input logic [31:0] w, input int k);
    logic [7:0] b;
    b = w[8*k +: 8];
    return int'($signed(b));
  endfunction

  task automatic core_compute();
    int len, outn, acc;
    len  = bus.core_len_64 ? 64 : 32;
    outn = bus.core_out_64 ? 64 : 32;
    for (int i = 0; i < 64; i++) begin
      acc = 0;
      if (i < outn) begin
        for (int j = 0; j < len; j++) acc += int'(wbuf[i*len+j]) * int'(xbuf[j]);
        if (bus.core_bias_en) acc += int'(bbuf[i]);
      end
      ybuf[i] = acc;
    end
  endtask

  always @(posedge clk) begin
    if (!reset && bus.core_y_rd_en) begin
      y_adv = 1'b1;
      n_yrd++;
    end
  end

  // Memory and core models: decide at the falling edge what the next rising edge sees.
  always @(negedge clk) begin
    if (reset) begin
      rd_pend = 0; wr_pend = 0; core_cnt = 0; y_adv = 0;
      xi = 0; wi = 0; bi = 0; yi = 0;
      bus.mem_rd_valid = 1'b0; bus.mem_rd_data = '0; bus.mem_wr_ack = 1'b0;
      bus.core_done = 1'b0; bus.core_busy = 1'b0; bus.core_y_rd_data = '0;
    end else begin
      bus.mem_rd_valid = 1'b0;
      bus.mem_wr_ack = 1'b0;
      if (y_adv) begin yi++; y_adv = 0; end
      if (bus.core_clear_done) begin
        xi = 0; wi = 0; bi = 0; yi = 0; bus.core_done = 1'b0; n_clr++;
      end
      if (int'(bus.core_x_wr_en) + int'(bus.core_w_wr_en) + int'(bus.core_b_wr_en) > 1) n_ov++;
      if (bus.core_x_wr_en) begin if (xi < 64) xbuf[xi] = bus.core_x_wr_data; xi++; n_x++; end
      if (bus.core_w_wr_en) begin if (wi < 4096) wbuf[wi] = bus.core_w_wr_data; wi++; n_w++; end
      if (bus.core_b_wr_en) begin if (bi < 64) bbuf[bi] = bus.core_b_wr_data; bi++; n_b++; end
      if (bus.core_start) begin
        n_start++; bus.core_busy = 1'b1; core_cnt = 3;
      end else if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin core_compute(); bus.core_done = 1'b1; bus.core_busy = 1'b0; end
      end
      if (bus.mem_rd_req) begin
        if (!rd_pend) begin
          rd_pend = 1; rd_hold = bus.mem_rd_addr; rd_stall = $urandom_range(0, max_stall);
        end else check("rd_addr_stable", bus.mem_rd_addr, rd_hold);
        if (rd_stall == 0) begin
          bus.mem_rd_valid = 1'b1;
          bus.mem_rd_data = mem[bus.mem_rd_addr[12:0]];
          rd_pend = 0;
          rd_log.push_back(bus.mem_rd_addr);
        end else rd_stall--;
      end
      if (bus.mem_wr_req) begin
        if (!wr_pend) begin
          wr_pend = 1; wr_hold_a = bus.mem_wr_addr; wr_hold_d = bus.mem_wr_data;
          wr_stall = $urandom_range(0, max_stall);
        end else begin
          check("wr_addr_stable", bus.mem_wr_addr, wr_hold_a);
          check("wr_data_stable", bus.mem_wr_data, wr_hold_d);
        end
        if (wr_stall == 0) begin
          wr_t e;
          bus.mem_wr_ack = 1'b1;
          wr_pend = 0;
          n_wr++;
          mem[bus.mem_wr_addr[12:0]] = bus.mem_wr_data;
          check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("wr_addr", bus.mem_wr_addr, e.addr);
            check("wr_data", bus.mem_wr_data, e.data);
          end
        end else wr_stall--;
      end
      bus.core_y_rd_data = (yi < 64) ? ybuf[yi] : 32'd0;
    end
  end

  task automatic fill(input logic [31:0] xw, input logic [31:0] ww);
    for (int i = 0; i < 16; i++) mem[X_BASE[12:0] + 13'(i)] = xw;
    for (int i = 0; i < 1024; i++) mem[W_BASE[12:0] + 13'(i)] = ww;
  endtask

  task automatic start_job(input bit l64, input bit o64, input bit ben, input bit rel, input int stall);
    int len, acc;
    wr_t e;
    len = l64 ? 64 : 32;
    exp_ny = o64 ? 64 : 32;
    exp_nx = len / 4;
    exp_nw = exp_ny * len / 4;
    exp_nb = ben ? exp_ny : 0;
    max_stall = stall;
    for (int i = 0; i < 64; i++) mem[Y_BASE[12:0] + 13'(i)] = 32'hDEADBEEF;
    for (int i = 0; i < exp_ny; i++) begin
      acc = ben ? int'(mem[B_BASE[12:0] + 13'(i)]) : 0;
      for (int j = 0; j < len; j++)
        acc += sbyte(mem[W_BASE[12:0] + 13'((i*len+j)/4)], (i*len+j) % 4) *
               sbyte(mem[X_BASE[12:0] + 13'(j/4)], j % 4);
      if (rel && acc < 0) acc = 0;
      e.addr = Y_BASE + 32'(i);
      e.data = acc;
      sb.push_back(e);
    end
    r0 = rd_log.size(); x0 = n_x; w0 = n_w; b0 = n_b; s0 = n_start;
    cl0 = n_clr; wr0 = n_wr; yr0 = n_yrd; ov0 = n_ov;
    cfg_x_base = X_BASE; cfg_w_base = W_BASE; cfg_b_base = B_BASE; cfg_y_base = Y_BASE;
    cfg_len_64 = l64; cfg_out_64 = o64; cfg_bias_en = ben; cfg_relu_en = rel;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_done", 32'(done), 32'd0);
  endtask

  task automatic finish_job(input string tag);
    int k, err;
    logic [31:0] c, ea;
    k = 0;
    while (!done && k < 40000) begin @(negedge clk); k++; end
    check($sformatf("%s_done", tag), 32'(done), 32'd1);
    check($sformatf("%s_busy", tag), 32'(busy), 32'd0);
    check($sformatf("%s_reads", tag), 32'(rd_log.size() - r0), 32'(exp_nx + exp_nw + exp_nb));
    err = 0;
    for (int m = 0; m < exp_nx + exp_nw + exp_nb && r0 + m < rd_log.size(); m++) begin
      if (m < exp_nx) ea = X_BASE + 32'(m);
      else if (m < exp_nx + exp_nw) ea = W_BASE + 32'(m - exp_nx);
      else ea = B_BASE + 32'(m - exp_nx - exp_nw);
      if (rd_log[r0+m] !== ea) err++;
    end
    check($sformatf("%s_rd_order_errs", tag), 32'(err), 32'd0);
    check($sformatf("%s_x_push", tag), 32'(n_x - x0), 32'(exp_nx * 4));
    check($sformatf("%s_w_push", tag), 32'(n_w - w0), 32'(exp_nw * 4));
    check($sformatf("%s_b_push", tag), 32'(n_b - b0), 32'(exp_nb));
    check($sformatf("%s_start", tag), 32'(n_start - s0), 32'd1);
    check($sformatf("%s_clear", tag), 32'(n_clr - cl0), 32'd2);
    check($sformatf("%s_writes", tag), 32'(n_wr - wr0), 32'(exp_ny));
    check($sformatf("%s_y_rd_en", tag), 32'(n_yrd - yr0), 32'(exp_ny));
    check($sformatf("%s_overlap", tag), 32'(n_ov - ov0), 32'd0);
    check($sformatf("%s_sb_left", tag), 32'(sb.size()), 32'd0);
    c = cycles;
    repeat (3) @(negedge clk);
    check($sformatf("%s_cycles_frozen", tag), cycles, c);
  endtask

  function automatic int y_errs(input int n, input logic [31:0] base_val, input bit ramp);
    int err;
    err = 0;
    for (int i = 0; i < n; i++)
      if (mem[Y_BASE[12:0] + 13'(i)] !== base_val + (ramp ? 32'(i) : 32'd0)) err++;
    return err;
  endfunction

  logic [31:0] y_save [0:31];

  initial begin
    int err, k;
    logic [31:0] c0;
    reset = 1'b1; go = 1'b0;
    cfg_x_base = '0; cfg_w_base = '0; cfg_b_base = '0; cfg_y_base = '0;
    cfg_len_64 = 0; cfg_out_64 = 0; cfg_bias_en = 0; cfg_relu_en = 0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", 32'({busy, done, bus.mem_rd_req, bus.mem_wr_req, bus.core_x_wr_en,
          bus.core_w_wr_en, bus.core_b_wr_en, bus.core_start, bus.core_clear_done,
          bus.core_len_64, bus.core_out_64, bus.core_bias_en, bus.core_y_rd_en}), 32'd0);
    check("rst_cycles", cycles, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    fill(32'h01010101, 32'h01010101);
    start_job(0, 0, 0, 0, 0);
    finish_job("j1");
    check("j1_y32", 32'(y_errs(32, 32'd32, 0)), 32'd0);

    fill(32'h02020202, 32'h01010101);
    for (int i = 0; i < 64; i++) mem[B_BASE[12:0] + 13'(i)] = 32'(i);
    start_job(1, 1, 1, 0, 0);
    finish_job("j2");
    check("j2_y128pi", 32'(y_errs(64, 32'd128, 1)), 32'd0);

    fill(32'h01010101, 32'hFFFFFFFF);
    start_job(0, 0, 0, 1, 0);
    finish_job("j3");
    check("j3_relu0", 32'(y_errs(32, 32'd0, 0)), 32'd0);
    start_job(0, 0, 0, 0, 0);
    finish_job("j4");
    check("j4_neg32", 32'(y_errs(32, 32'hFFFFFFE0, 0)), 32'd0);

    for (int i = 0; i < 16; i++) mem[X_BASE[12:0] + 13'(i)] = $urandom;
    for (int i = 0; i < 1024; i++) mem[W_BASE[12:0] + 13'(i)] = $urandom;
    for (int i = 0; i < 64; i++) mem[B_BASE[12:0] + 13'(i)] = $urandom;
    start_job(1, 0, 1, 0, 0);
    finish_job("j5");
    for (int i = 0; i < 32; i++) y_save[i] = mem[Y_BASE[12:0] + 13'(i)];
    start_job(1, 0, 1, 0, 5);
    finish_job("j6_stall");
    err = 0;
    for (int i = 0; i < 32; i++) if (mem[Y_BASE[12:0] + 13'(i)] !== y_save[i]) err++;
    check("j6_same_as_nostall", 32'(err), 32'd0);

    fill(32'h01010101, 32'h01010101);
    start_job(0, 0, 0, 0, 3);
    repeat (60) @(negedge clk);
    c0 = cycles;
    cfg_len_64 = 1; cfg_out_64 = 1; cfg_bias_en = 1; cfg_relu_en = 1; cfg_y_base = Y_ALT;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check("j7_cycles_not_cleared", cycles, c0 + 32'd1);
    check("j7_still_busy", 32'(busy), 32'd1);
    finish_job("j7");
    check("j7_y32", 32'(y_errs(32, 32'd32, 0)), 32'd0);

    start_job(1, 1, 1, 0, 0);
    k = 0;
    while ((rd_log.size() - r0) < 56 && k < 5000) begin @(negedge clk); k++; end
    check("j8_reached_ld_w", 32'((rd_log.size() - r0) >= 56), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("j8_rst_ctrl", 32'({busy, done, bus.mem_rd_req, bus.mem_wr_req, bus.core_x_wr_en,
          bus.core_w_wr_en, bus.core_b_wr_en, bus.core_start, bus.core_clear_done,
          bus.core_len_64, bus.core_out_64, bus.core_bias_en, bus.core_y_rd_en}), 32'd0);
    check("j8_rst_cycles", cycles, 32'd0);
    check("j8_rst_data", bus.mem_rd_addr | bus.mem_wr_addr | bus.mem_wr_data |
          bus.core_b_wr_data | {16'd0, bus.core_x_wr_data, bus.core_w_wr_data}, 32'd0);
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    start_job(0, 0, 0, 0, 2);
    finish_job("j9");
    check("j9_y32", 32'(y_errs(32, 32'd32, 0)), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
